// File: rtl/serial_adder_ctrl_if.sv
// Operand and result valid/ready bundle for serial_adder_ctrl.
// o_overflow exists only when SERIAL_ADDER_CTRL_OVERFLOW_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_carry_in;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_s;
    logic             o_carry_out;
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
    logic             o_overflow;
`endif

    modport slave (
        input  i_valid, i_a, i_b, i_carry_in, i_ready,
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
        output o_overflow,
`endif
        output o_ready, o_valid, o_s, o_carry_out
    );

    modport master (
        output i_valid, i_a, i_b, i_carry_in, i_ready,
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
        input  o_overflow,
`endif
        input  o_ready, o_valid, o_s, o_carry_out
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Wide adder that time-shares one 4-bit ripple adder, one nibble per cycle.
// Define SERIAL_ADDER_CTRL_OVERFLOW_EN to add the signed-overflow output.
module serial_adder_ctrl_rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    serial_adder_ctrl_if.slave      bus
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             co_q, co_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             ovf_q, ovf_d;
`endif

    logic [3:0] nib_s;
    logic       nib_co;

    serial_adder_ctrl_rca4 u_rca (
        .a  (a_q[3:0]),
        .b  (b_q[3:0]),
        .ci (cy_q),
        .s  (nib_s),
        .co (nib_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        co_d    = co_q;
        ready_d = ready_q;
        valid_d = valid_q;
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid && ready_q) begin
                    a_d     = bus.i_a;
                    b_d     = bus.i_b;
                    cy_d    = bus.i_carry_in;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = RUN;
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
                    amsb_d  = bus.i_a[WIDTH-1];
                    bmsb_d  = bus.i_b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                // sum nibbles enter at the top so the LSB nibble lands at bit 0
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                cy_d  = nib_co;
                res_d = (res_q >> 4) | (WIDTH'(nib_s) << (WIDTH - 4));
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    s_d     = res_d;
                    co_d    = nib_co;
                    valid_d = 1'b1;
                    state_d = DONE;
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
                    ovf_d   = (amsb_q == bmsb_q) && (nib_s[3] != amsb_q);
`endif
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            co_q    <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            co_q    <= co_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.o_ready     = ready_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_s         = s_q;
    assign bus.o_carry_out = co_q;
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
    assign bus.o_overflow  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: 32-bit and 4-bit instances.
// Overflow checks compile in with SERIAL_ADDER_CTRL_OVERFLOW_EN.
module tb_serial_adder_ctrl;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    serial_adder_ctrl_if #(.WIDTH(32)) io ();
    serial_adder_ctrl_if #(.WIDTH(4))  io4 ();

    serial_adder_ctrl #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (io)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (io4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic ci, output int acc);
        io.i_a        = a;
        io.i_b        = b;
        io.i_carry_in = ci;
        io.i_valid    = 1'b1;
        acc           = -1;
        for (int k = 0; k < 50; k++) begin
            if (io.o_ready) begin
                @(posedge clk);
                #1;
                acc        = cyc;
                io.i_valid = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            io.i_valid = 1'b0;
            timeout("accept");
        end
    endtask

    task automatic wait_valid(output int lat, output logic rdy1);
        lat  = 0;
        rdy1 = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) rdy1 = io.o_ready;
            if (io.o_valid) break;
        end
        if (!io.o_valid) timeout("result_valid");
    endtask

    task automatic drain();
        io.i_ready = 1'b1;
        @(posedge clk);
        #1;
        io.i_ready = 1'b0;
    endtask

    int   acc1, acc2, lat;
    logic rdy1;

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        io.i_valid = 1'b0; io.i_a = '0; io.i_b = '0;
        io.i_carry_in = 1'b0; io.i_ready = 1'b0;
        io4.i_valid = 1'b0; io4.i_a = '0; io4.i_b = '0;
        io4.i_carry_in = 1'b0; io4.i_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_ready", io.o_ready, 1);
        chk("rst_valid", io.o_valid, 0);
        chk("rst_s", io.o_s, 0);
        chk("rst_co", io.o_carry_out, 0);
        chk("rst4_ready", io4.o_ready, 1);
        chk("rst4_s", io4.o_s, 0);
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
        chk("rst_ovf", io.o_overflow, 0);
`endif

        // 1 + FFFFFFFF: full carry ripple, latency 9
        send(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, acc1);
        wait_valid(lat, rdy1);
        chk("t1_run_ready", rdy1, 0);
        chk("t1_latency", lat, 9);
        chk("t1_s", io.o_s, 64'h0);
        chk("t1_co", io.o_carry_out, 1);
        drain();

        // back-to-back with i_ready held high
        io.i_ready = 1'b1;
        send(32'h1234_5678, 32'h1111_1111, 1'b1, acc1);
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, acc2);
        chk("t2_interval", acc2 - acc1, 10);
        chk("t2_s", io.o_s, 64'h2345_678A);
        chk("t2_co", io.o_carry_out, 0);
        io.i_ready = 1'b0;
        wait_valid(lat, rdy1);
        chk("t2b_latency", lat, 9);
        chk("t2b_s", io.o_s, 64'h100);

        // stall in DONE with new operands offered
        io.i_a = 32'd5; io.i_b = 32'd6; io.i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_valid", io.o_valid, 1);
            chk("t3_ready", io.o_ready, 0);
            chk("t3_s", io.o_s, 64'h100);
        end
        io.i_ready = 1'b1;
        @(posedge clk);
        #1;
        io.i_ready = 1'b0;
        @(negedge clk);
        chk("t3_idle_ready", io.o_ready, 1);
        chk("t3_idle_valid", io.o_valid, 0);
        chk("t3_idle_s", io.o_s, 64'h100);
        send(32'd5, 32'd6, 1'b0, acc1);
        wait_valid(lat, rdy1);
        chk("t3_new_s", io.o_s, 64'hB);
        chk("t3_new_lat", lat, 9);
        drain();

        // reset pulse in RUN cycle 4
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, acc1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4_valid", io.o_valid, 0);
        chk("t4_s", io.o_s, 0);
        chk("t4_co", io.o_carry_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t4_ready", io.o_ready, 1);
        send(32'd3, 32'd4, 1'b0, acc1);
        wait_valid(lat, rdy1);
        chk("t4_s7", io.o_s, 64'h7);
        chk("t4_co7", io.o_carry_out, 0);
        chk("t4_lat", lat, 9);
        drain();

        // carry-in propagates across every nibble
        send(32'hFFFF_FFFF, 32'h0, 1'b1, acc1);
        wait_valid(lat, rdy1);
        chk("t5_s", io.o_s, 64'h0);
        chk("t5_co", io.o_carry_out, 1);
        drain();

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, acc1);
        wait_valid(lat, rdy1);
        chk("t6_s", io.o_s, 64'h8000_0000);
        chk("t6_co", io.o_carry_out, 0);
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
        chk("t6_ovf", io.o_overflow, 1);
`endif
        drain();

        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, acc1);
        wait_valid(lat, rdy1);
        chk("t7_s", io.o_s, 64'h0);
        chk("t7_co", io.o_carry_out, 1);
`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
        chk("t7_ovf", io.o_overflow, 0);
`endif
        drain();

        // 4-bit instance: single RUN cycle
        @(negedge clk);
        io4.i_a = 4'hF; io4.i_b = 4'h1; io4.i_carry_in = 1'b0;
        io4.i_valid = 1'b1;
        @(posedge clk);
        #1;
        io4.i_valid = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (io4.o_valid) break;
        end
        if (!io4.o_valid) timeout("w4_valid");
        chk("w4_latency", lat, 2);
        chk("w4_s", io4.o_s, 64'h0);
        chk("w4_co", io4.o_carry_out, 1);
        io4.i_ready = 1'b1;
        @(posedge clk);
        #1;
        io4.i_ready = 1'b0;
        @(negedge clk);
        chk("w4_ready", io4.o_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
